// File: rtl/mem_arbiter_if.sv
// Request, grant and RAM-side signals for the two-port memory arbiter.
// The arbiter uses the slave modport; requesters and RAM use the master modport.
interface mem_arbiter_if #(
    parameter int DW = 16,
    parameter int AW = 16
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_rvalid;

    logic          ldr_req;
    logic          ldr_we;
    logic [AW-1:0] ldr_addr;
    logic [DW-1:0] ldr_wdata;
    logic          ldr_gnt;
    logic          ldr_rvalid;

    logic [DW-1:0] rdata;
    logic          busy;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
        input  mem_rdata,
        output cpu_gnt, cpu_rvalid, ldr_gnt, ldr_rvalid,
        output rdata, busy,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata,
        output mem_rdata,
        input  cpu_gnt, cpu_rvalid, ldr_gnt, ldr_rvalid,
        input  rdata, busy,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between CPU (port 0) and loader (port 1).
// gnt one cycle after req is sampled in IDLE, read rvalid three cycles after; req is ignored while busy.
module mem_arbiter #(
    parameter int DW = 16,
    parameter int AW = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    mem_arbiter_if.slave bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RDATA  = 2'd2;

    logic [1:0]    r_state;
    logic          r_last;
    logic          r_id;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata;
    logic          r_cpu_rvalid;
    logic          r_ldr_rvalid;

    logic          w_any;
    logic          w_win;
    logic          w_access;

    assign w_any    = bus.cpu_req | bus.ldr_req;
    // On a tie the port not granted last wins; a lone requester always wins.
    assign w_win    = (bus.cpu_req & bus.ldr_req) ? ~r_last : bus.ldr_req;
    assign w_access = (r_state == S_ACCESS);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_last       <= 1'b1;
            r_id         <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_cpu_rvalid <= 1'b0;
            r_ldr_rvalid <= 1'b0;
        end else begin
            r_cpu_rvalid <= 1'b0;
            r_ldr_rvalid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_id    <= w_win;
                        r_we    <= w_win ? bus.ldr_we    : bus.cpu_we;
                        r_addr  <= w_win ? bus.ldr_addr  : bus.cpu_addr;
                        r_wdata <= w_win ? bus.ldr_wdata : bus.cpu_wdata;
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    r_last  <= r_id;
                    r_state <= r_we ? S_IDLE : S_RDATA;
                end
                S_RDATA: begin
                    r_rdata      <= bus.mem_rdata;
                    r_cpu_rvalid <= ~r_id;
                    r_ldr_rvalid <= r_id;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Strobes derive from the state so a reset mid-access kills them immediately.
    assign bus.cpu_gnt    = w_access & ~r_id;
    assign bus.ldr_gnt    = w_access & r_id;
    assign bus.cpu_rvalid = r_cpu_rvalid;
    assign bus.ldr_rvalid = r_ldr_rvalid;
    assign bus.rdata      = r_rdata;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.mem_en     = w_access;
    assign bus.mem_we     = w_access & r_we;
    assign bus.mem_addr   = r_addr;
    assign bus.mem_wdata  = r_wdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed stimulus for mem_arbiter; expected grants and read returns are queued
// at issue time and popped by an independent monitor.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter_if #(.DW(16), .AW(16)) bus ();

    mem_arbiter #(.DW(16), .AW(16)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    typedef struct {
        bit          port;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          lat;
        int          t0;
    } gexp_t;

    typedef struct {
        bit          port;
        logic [15:0] data;
        int          lat;
        int          t0;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];

    logic [15:0] ram [0:255];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic exp_gnt(input bit port, input bit we, input logic [15:0] a,
                           input logic [15:0] wd, input int lat);
        gexp_t g;
        g.port = port; g.we = we; g.addr = a; g.wdata = wd; g.lat = lat; g.t0 = cyc;
        gq.push_back(g);
    endtask

    task automatic exp_rv(input bit port, input logic [15:0] d, input int lat);
        rexp_t r;
        r.port = port; r.data = d; r.lat = lat; r.t0 = cyc;
        rq.push_back(r);
    endtask

    // Raise a request, hold it until the grant, then drop it.
    task automatic do_req(input bit port, input bit we, input logic [15:0] a, input logic [15:0] wd);
        bit got;
        got = 1'b0;
        if (port) begin
            bus.ldr_req = 1'b1; bus.ldr_we = we; bus.ldr_addr = a; bus.ldr_wdata = wd;
        end else begin
            bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = wd;
        end
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            got = port ? bus.ldr_gnt : bus.cpu_gnt;
        end
        if (!got) check("gnt_timeout", 32'(got), 32'd1);
        if (port) bus.ldr_req = 1'b0;
        else      bus.cpu_req = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            done = (gq.size() == 0) && (rq.size() == 0) && !bus.busy;
        end
        check("drain_pending", 32'(gq.size() + rq.size()), 32'd0);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // RAM model: synchronous single port, read data one cycle after mem_en.
    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
        ram[8'h10] = 16'h1234;
        ram[8'h11] = 16'hABCD;
        ram[8'h12] = 16'h0F0F;
        ram[8'h20] = 16'hA020;
        ram[8'h21] = 16'hA021;
        ram[8'h22] = 16'hA022;
        ram[8'h30] = 16'hB030;
        ram[8'h31] = 16'hB031;
        ram[8'h32] = 16'hB032;
        bus.mem_rdata = 16'h0000;
        forever begin
            @(posedge clk);
            if (bus.mem_en) begin
                if (bus.mem_we) ram[bus.mem_addr[7:0]] = bus.mem_wdata;
                else            bus.mem_rdata <= ram[bus.mem_addr[7:0]];
            end
        end
    end

    // Monitor
    initial begin
        gexp_t g;
        rexp_t r;
        forever begin
            @(negedge clk);
            if (bus.cpu_gnt | bus.ldr_gnt) begin
                if (gq.size() == 0) begin
                    check("gnt_unexpected", 32'({bus.cpu_gnt, bus.ldr_gnt}), 32'd0);
                end else begin
                    g = gq.pop_front();
                    check("gnt_port", 32'({bus.cpu_gnt, bus.ldr_gnt}), g.port ? 32'd1 : 32'd2);
                    check("gnt_mem_en", 32'(bus.mem_en), 32'd1);
                    check("gnt_mem_we", 32'(bus.mem_we), 32'(g.we));
                    check("gnt_mem_addr", 32'(bus.mem_addr), 32'(g.addr));
                    check("gnt_mem_wdata", 32'(bus.mem_wdata), 32'(g.wdata));
                    check("gnt_busy", 32'(bus.busy), 32'd1);
                    if (g.lat >= 0) check("gnt_latency", 32'(cyc - g.t0), 32'(g.lat));
                end
            end else if (bus.mem_en) begin
                check("mem_en_without_gnt", 32'(bus.mem_en), 32'd0);
            end
            if (bus.cpu_rvalid | bus.ldr_rvalid) begin
                if (rq.size() == 0) begin
                    check("rvalid_unexpected", 32'({bus.cpu_rvalid, bus.ldr_rvalid}), 32'd0);
                end else begin
                    r = rq.pop_front();
                    check("rvalid_port", 32'({bus.cpu_rvalid, bus.ldr_rvalid}), r.port ? 32'd1 : 32'd2);
                    check("rdata", 32'(bus.rdata), 32'(r.data));
                    if (r.lat >= 0) check("rvalid_latency", 32'(cyc - r.t0), 32'(r.lat));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0; bus.cpu_wdata = 16'h0;
        bus.ldr_req = 1'b0; bus.ldr_we = 1'b0; bus.ldr_addr = 16'h0; bus.ldr_wdata = 16'h0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_mem_en", 32'(bus.mem_en), 32'd0);
        check("rst_gnt", 32'({bus.cpu_gnt, bus.ldr_gnt}), 32'd0);
        check("rst_rvalid", 32'({bus.cpu_rvalid, bus.ldr_rvalid}), 32'd0);
        check("rst_rdata", 32'(bus.rdata), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        rst = 1'b0;

        // CPU read alone
        @(negedge clk);
        exp_gnt(1'b0, 1'b0, 16'h0010, 16'h0000, 1);
        exp_rv(1'b0, 16'h1234, 3);
        do_req(1'b0, 1'b0, 16'h0010, 16'h0000);
        wait_idle();
        repeat (2) @(negedge clk);
        check("rdata_hold", 32'(bus.rdata), 32'h1234);

        // Loader write alone
        exp_gnt(1'b1, 1'b1, 16'h0005, 16'hBEEF, 1);
        do_req(1'b1, 1'b1, 16'h0005, 16'hBEEF);
        wait_idle();
        check("ram_write_5", 32'(ram[8'h05]), 32'hBEEF);
        check("rdata_hold_after_write", 32'(bus.rdata), 32'h1234);

        // Simultaneous writes straight after reset: CPU first, loader 2 cycles later
        reset_pulse();
        exp_gnt(1'b0, 1'b1, 16'h0006, 16'h1111, 1);
        exp_gnt(1'b1, 1'b1, 16'h0007, 16'h2222, 3);
        fork
            do_req(1'b0, 1'b1, 16'h0006, 16'h1111);
            do_req(1'b1, 1'b1, 16'h0007, 16'h2222);
        join
        wait_idle();
        check("ram_write_6", 32'(ram[8'h06]), 32'h1111);
        check("ram_write_7", 32'(ram[8'h07]), 32'h2222);

        // Continuous dual reads: strict C,L,C,L,C,L
        @(negedge clk);
        exp_gnt(1'b0, 1'b0, 16'h0020, 16'h0, 1);  exp_rv(1'b0, 16'hA020, 3);
        exp_gnt(1'b1, 1'b0, 16'h0030, 16'h0, -1); exp_rv(1'b1, 16'hB030, -1);
        exp_gnt(1'b0, 1'b0, 16'h0021, 16'h0, -1); exp_rv(1'b0, 16'hA021, -1);
        exp_gnt(1'b1, 1'b0, 16'h0031, 16'h0, -1); exp_rv(1'b1, 16'hB031, -1);
        exp_gnt(1'b0, 1'b0, 16'h0022, 16'h0, -1); exp_rv(1'b0, 16'hA022, -1);
        exp_gnt(1'b1, 1'b0, 16'h0032, 16'h0, -1); exp_rv(1'b1, 16'hB032, -1);
        fork
            for (int k = 0; k < 3; k++) begin
                do_req(1'b0, 1'b0, 16'h0020 + 16'(k), 16'h0);
                @(negedge clk);
            end
            for (int k = 0; k < 3; k++) begin
                do_req(1'b1, 1'b0, 16'h0030 + 16'(k), 16'h0);
                @(negedge clk);
            end
        join
        wait_idle();

        // Address changes while the read is in RDATA
        exp_gnt(1'b0, 1'b0, 16'h0011, 16'h0, 1);
        exp_rv(1'b0, 16'hABCD, 3);
        do_req(1'b0, 1'b0, 16'h0011, 16'h0);
        @(negedge clk);
        bus.cpu_addr = 16'h0012;
        wait_idle();

        // Reset in RDATA aborts the read; loader req held through reset is served next
        exp_gnt(1'b0, 1'b0, 16'h0010, 16'h0, 1);
        do_req(1'b0, 1'b0, 16'h0010, 16'h0);
        @(negedge clk);
        check("rdata_state_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        bus.ldr_req = 1'b1; bus.ldr_we = 1'b1; bus.ldr_addr = 16'h0040; bus.ldr_wdata = 16'h5555;
        exp_gnt(1'b1, 1'b1, 16'h0040, 16'h5555, 2);
        @(negedge clk);
        rst = 1'b0;
        check("abort_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_gnt", 32'({bus.cpu_gnt, bus.ldr_gnt}), 32'd0);
        check("abort_mem_en_we", 32'({bus.mem_en, bus.mem_we}), 32'd0);
        check("abort_rdata", 32'(bus.rdata), 32'd0);
        check("abort_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("abort_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        do_req(1'b1, 1'b1, 16'h0040, 16'h5555);
        wait_idle();
        check("ram_write_40", 32'(ram[8'h40]), 32'h5555);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
